// File: rtl/int_ctrl.sv
// int_ctrl: prioritised interrupt controller for the CPU core.
// Synchronises and edge-detects up to 8 request lines, latches them as
// pending, and drives the interrupt/intVect/intAck handshake. The
// ENABLE/PENDING/ACTIVE registers are mapped at 0x10(IO_BASE)..+3.
// Optional build macro INT_CTRL_LEVEL_EN adds a LEVEL register at offset 3
// that makes selected sources level-sensitive.
module int_ctrl #(
  parameter int              N_IRQ      = 8,
  parameter logic [7:0]      IO_BASE    = 8'h80,
  parameter logic [15:0]     VECT_BASE  = 16'h0008,
  parameter int              VECT_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [15:0]      ioAddress,
  input  logic [7:0]       ioDataIn,
  input  logic             ioWriteEn,
  input  logic             ioReadEn,
  output logic [7:0]       ioDataOut,
  output logic             interrupt,
  output logic [15:0]      intVect,
  input  logic             intAck
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Bits at or above N_IRQ are tied off everywhere through this mask.
  localparam logic [7:0] IRQ_MASK = 8'hFF >> (8 - N_IRQ);

  logic [7:0]  irq_w;
  logic [7:0]  sync1_q, sync2_q, prev_q;
  logic [7:0]  edge_w;
  logic [7:0]  enable_q, enable_d;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  req_w;
  logic [7:0]  ack_clr_w, w1c_w;
  logic [7:0]  rd_data_w;
  logic [7:0]  dout_d;
  logic [1:0]  state_q, state_d;
  logic [2:0]  cur_idx_q, cur_idx_d;
  logic [2:0]  first_idx_w;
  logic [15:0] vect_q, vect_d;
  logic        int_q, int_d;
  logic        hit_w, wr_w, rd_w, ack_w;
  logic [1:0]  off_w;
`ifdef INT_CTRL_LEVEL_EN
  logic [7:0]  level_q, level_d;
`endif

  // Widen the request lines to 8 bits, unused positions held at 0.
  always_comb begin
    irq_w = '0;
    for (int i = 0; i < N_IRQ; i++) irq_w[i] = irq_in[i];
  end

  // Two-flop synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= irq_w;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_w = sync2_q & ~prev_q & IRQ_MASK;

  assign hit_w = (ioAddress[15:8] == 8'h10) && (ioAddress[7:2] == IO_BASE[7:2]);
  assign off_w = ioAddress[1:0];
  assign wr_w  = ioWriteEn && hit_w;
  assign rd_w  = ioReadEn && hit_w;
  assign ack_w = intAck && (state_q == S_REQ);

  // Register writes and pending update; a new edge wins over any clear.
  always_comb begin
    enable_d  = enable_q;
    w1c_w     = '0;
    ack_clr_w = '0;
    if (wr_w && off_w == 2'd0) enable_d = ioDataIn & IRQ_MASK;
    if (wr_w && off_w == 2'd1) w1c_w = ioDataIn;
    if (ack_w) ack_clr_w = 8'd1 << cur_idx_q;
    pend_d = ((pend_q & ~(ack_clr_w | w1c_w)) | edge_w) & IRQ_MASK;
`ifdef INT_CTRL_LEVEL_EN
    level_d = level_q;
    if (wr_w && off_w == 2'd3) level_d = ioDataIn & IRQ_MASK;
    // Level sources mirror the synchronised line; clears cannot touch them.
    pend_d = ((pend_d & ~level_q) | (sync2_q & level_q)) & IRQ_MASK;
`endif
  end

  // Lowest-numbered enabled pending source has the highest priority.
  always_comb begin
    req_w       = pend_q & enable_q;
    first_idx_w = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req_w[i]) first_idx_w = i[2:0];
    end
  end

  // Handshake FSM: IDLE picks a source, REQ holds until ack, GAP forces
  // the extra low cycle so the core always sees two deasserted cycles.
  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    case (state_q)
      S_IDLE: begin
        if (|req_w) begin
          state_d   = S_REQ;
          cur_idx_d = first_idx_w;
        end
      end
      S_REQ:   if (intAck) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    vect_d = VECT_BASE + (16'(cur_idx_d) << VECT_SHIFT);
    int_d  = (state_d == S_REQ);
  end

  // Read mux; the result is registered and returns 0 when not selected.
  always_comb begin
    case (off_w)
      2'd0:    rd_data_w = enable_q;
      2'd1:    rd_data_w = pend_q;
      2'd2:    rd_data_w = {state_q != S_IDLE, 4'b0000, cur_idx_q};
`ifdef INT_CTRL_LEVEL_EN
      default: rd_data_w = level_q;
`else
      default: rd_data_w = 8'h00;
`endif
    endcase
    dout_d = rd_w ? rd_data_w : 8'h00;
  end

  // Control and register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q  <= '0;
      pend_q    <= '0;
      state_q   <= S_IDLE;
      cur_idx_q <= '0;
      vect_q    <= VECT_BASE;
      int_q     <= 1'b0;
      ioDataOut <= '0;
    end else begin
      enable_q  <= enable_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      vect_q    <= vect_d;
      int_q     <= int_d;
      ioDataOut <= dout_d;
    end
  end

`ifdef INT_CTRL_LEVEL_EN
  // LEVEL register: selects level-sensitive sources.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= '0;
    else       level_q <= level_d;
  end
`endif

  assign interrupt = int_q;
  assign intVect   = vect_q;

endmodule
